multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle opcode decoder of the CPU.
- Sequences each instruction through FETCH/DECODE/execute states.
- Stalls on the multi-cycle multiply/divide unit and on the data-memory ready handshake.
- Drives the same datapath controls plus sequencing strobes (irWrite, pcWrite, mdStart), halt and fault flags. Sits between the instruction register and the datapath muxes/register file.

---
 rtl/multicycle_control.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer for the CPU datapath.
// Each instruction walks FETCH -> DECODE -> execute state(s) -> FETCH. The
// block stalls for the multiply/divide unit and for the data-memory ready
// handshake.
// Optional build macro ILLEGAL_TRAP_EN: when defined, an illegal opcode/function
// halts the core and illegalOp stays high until reset. When undefined, an
// illegal instruction behaves as a NOP and flags illegalOp for its DECODE cycle.
module multicycle_control #(
    parameter int OPCODE_W      = 4,
    parameter int FUNC_W        = 4,
    parameter int MULDIV_CYCLES = 16,
    parameter int MEM_TIMEOUT   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opCode,
    input  logic [FUNC_W-1:0]   functionCode,
    input  logic                branchTaken,
    input  logic                memReady,
    output logic                irWrite,
    output logic                pcWrite,
    output logic [1:0]          pcSource,
    output logic                regWrite,
    output logic                r0Write,
    output logic                aluSource,
    output logic                aluSource2,
    output logic                memRead,
    output logic                memWrite,
    output logic                memSource,
    output logic                mdStart,
    output logic                halt,
    output logic                busy,
    output logic                illegalOp,
    output logic                memFault
);

    // One counter serves both multi-cycle states: it counts down in MULDIV
    // and counts up (wait cycles) in MEM.
    localparam int CNT_MAX = (MULDIV_CYCLES > MEM_TIMEOUT) ? MULDIV_CYCLES : MEM_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MD_FIRST = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MULDIV,
        MEM,
        BRANCH,
        JUMP,
        HALTED
    } state_t;

    state_t              state;
    state_t              dispatch;
    logic                illegal;
    logic [OPCODE_W-1:0] op_reg;
    logic [FUNC_W-1:0]   func_reg;
    logic [CNT_W-1:0]    cnt;
    logic                op_hi_zero;
    logic                func_hi_zero;
    logic [3:0]          op_lo;
    logic [3:0]          func_lo;
    logic                is_store;
    logic                exec_imm;
`ifdef ILLEGAL_TRAP_EN
    logic                illegal_sticky;
`endif

    // Bits above the 4-bit encoding must be zero for a legal instruction.
    assign op_hi_zero   = ((opCode >> 4) == '0);
    assign func_hi_zero = ((functionCode >> 4) == '0);
    assign op_lo        = opCode[3:0];
    assign func_lo      = functionCode[3:0];

    // Facts about the latched instruction used by the execute states.
    assign is_store = (op_reg == OPCODE_W'(11));
    assign exec_imm = (func_reg >= FUNC_W'(8)) && (func_reg <= FUNC_W'(11));

    // Dispatch decision made in DECODE from the instruction register contents.
    always_comb begin
        dispatch = FETCH;
        illegal  = 1'b0;
        if (!op_hi_zero) begin
            illegal = 1'b1;
        end else begin
            case (op_lo)
                4'b0000: begin
                    if (!func_hi_zero) begin
                        illegal = 1'b1;
                    end else if (func_lo == 4'b0001 || func_lo == 4'b0010) begin
                        dispatch = MULDIV;
                    end else begin
                        dispatch = EXEC;
                    end
                end
                4'b1000, 4'b1011:          dispatch = MEM;
                4'b0100, 4'b0101, 4'b0110: dispatch = BRANCH;
                4'b1100:                   dispatch = JUMP;
                4'b1111:                   dispatch = HALTED;
                default:                   illegal  = 1'b1;
            endcase
        end
        if (illegal) begin
`ifdef ILLEGAL_TRAP_EN
            dispatch = HALTED;
`else
            dispatch = FETCH;
`endif
        end
    end

    // Sequencer state, latched instruction fields and the shared cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            op_reg         <= '0;
            func_reg       <= '0;
            cnt            <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_sticky <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:   state <= FETCH;
                FETCH:  state <= DECODE;
                DECODE: begin
                    op_reg   <= opCode;
                    func_reg <= functionCode;
                    state    <= dispatch;
                    cnt      <= (dispatch == MULDIV) ? MD_FIRST : '0;
`ifdef ILLEGAL_TRAP_EN
                    if (illegal) begin
                        illegal_sticky <= 1'b1;
                    end
`endif
                end
                EXEC, BRANCH, JUMP: state <= FETCH;
                MULDIV: begin
                    if (cnt == '0) begin
                        state <= FETCH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MEM: begin
                    if (memReady || cnt == MEM_LAST) begin
                        state <= FETCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HALTED:  state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    // Control outputs decoded from the state and latched instruction; branch
    // and memory-completion strobes follow their handshake inputs directly.
    always_comb begin
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        pcSource   = 2'b00;
        regWrite   = 1'b0;
        r0Write    = 1'b0;
        aluSource  = 1'b0;
        aluSource2 = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memSource  = 1'b0;
        mdStart    = 1'b0;
        halt       = 1'b0;
        busy       = 1'b0;
        illegalOp  = 1'b0;
        memFault   = 1'b0;
        case (state)
            FETCH: begin
                irWrite = 1'b1;
                pcWrite = 1'b1;
            end
            DECODE: begin
`ifndef ILLEGAL_TRAP_EN
                illegalOp = illegal;
`endif
            end
            EXEC: begin
                regWrite   = 1'b1;
                aluSource2 = exec_imm;
            end
            MULDIV: begin
                busy    = 1'b1;
                mdStart = (cnt == MD_FIRST);
                if (cnt == '0) begin
                    regWrite = 1'b1;
                    r0Write  = 1'b1;
                end
            end
            MEM: begin
                busy      = 1'b1;
                aluSource = 1'b1;
                if (is_store) begin
                    memWrite   = 1'b1;
                    aluSource2 = 1'b1;
                end else begin
                    memRead   = 1'b1;
                    memSource = 1'b1;
                    regWrite  = memReady;
                end
                memFault = !memReady && (cnt == MEM_LAST);
            end
            BRANCH: begin
                pcSource = 2'b01;
                pcWrite  = branchTaken;
            end
            JUMP: begin
                pcSource = 2'b10;
                pcWrite  = 1'b1;
            end
            HALTED: begin
                halt = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                illegalOp = illegal_sticky;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A timeline model lists, per
// instruction, the expected control outputs for each cycle from FETCH onwards;
// each scenario task drives instructions and compares every cycle against it.
module tb_multicycle_control;

    localparam int N_MD      = 16;
    localparam int T_MEM     = 64;
    localparam int HALT_HOLD = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opCode = '0;
    logic [3:0] functionCode = '0;
    logic       branchTaken = 1'b0;
    logic       memReady = 1'b0;
    logic       irWrite, pcWrite, regWrite, r0Write, aluSource, aluSource2;
    logic       memRead, memWrite, memSource, mdStart, halt, busy, illegalOp, memFault;
    logic [1:0] pcSource;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       reg_write;
        logic       r0_write;
        logic       alu_src;
        logic       alu_src2;
        logic       mem_read;
        logic       mem_write;
        logic       mem_src;
        logic       md_start;
        logic       halt;
        logic       busy;
        logic       illegal_op;
        logic       mem_fault;
    } outs_t;

    outs_t got;
    outs_t exp_q[$];
    outs_t obs_q[$];
    int    n_checks = 0;
    int    n_pass = 0;

    multicycle_control #(
        .OPCODE_W(4), .FUNC_W(4), .MULDIV_CYCLES(N_MD), .MEM_TIMEOUT(T_MEM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .opCode(opCode), .functionCode(functionCode),
        .branchTaken(branchTaken), .memReady(memReady),
        .irWrite(irWrite), .pcWrite(pcWrite), .pcSource(pcSource),
        .regWrite(regWrite), .r0Write(r0Write), .aluSource(aluSource),
        .aluSource2(aluSource2), .memRead(memRead), .memWrite(memWrite),
        .memSource(memSource), .mdStart(mdStart), .halt(halt), .busy(busy),
        .illegalOp(illegalOp), .memFault(memFault)
    );

    assign got = {irWrite, pcWrite, pcSource, regWrite, r0Write, aluSource, aluSource2,
                  memRead, memWrite, memSource, mdStart, halt, busy, illegalOp, memFault};

    always #5 clk = ~clk;

    function automatic bit is_illegal(input logic [3:0] op);
        return !(op inside {4'd0, 4'd4, 4'd5, 4'd6, 4'd8, 4'd11, 4'd12, 4'd15});
    endfunction

    // Expected per-cycle outputs of one instruction, starting at its FETCH cycle.
    // rdy = MEM cycle (1-based) in which memReady is given; 0 = never.
    task automatic model_instr(input logic [3:0] op, input logic [3:0] fn,
                               input logic bt, input int rdy);
        outs_t v;
        int    n;
        exp_q.delete();
        v = '0; v.ir_write = 1'b1; v.pc_write = 1'b1;
        exp_q.push_back(v);
        v = '0;
        if (is_illegal(op)) begin
`ifdef ILLEGAL_TRAP_EN
            exp_q.push_back(v);
            for (int k = 0; k < HALT_HOLD; k++) begin
                v = '0; v.halt = 1'b1; v.illegal_op = 1'b1;
                exp_q.push_back(v);
            end
`else
            v.illegal_op = 1'b1;
            exp_q.push_back(v);
`endif
            return;
        end
        exp_q.push_back(v);
        case (op)
            4'd0: begin
                if (fn == 4'd1 || fn == 4'd2) begin
                    for (int k = 1; k <= N_MD; k++) begin
                        v = '0; v.busy = 1'b1;
                        v.md_start  = (k == 1);
                        v.reg_write = (k == N_MD);
                        v.r0_write  = (k == N_MD);
                        exp_q.push_back(v);
                    end
                end else begin
                    v = '0; v.reg_write = 1'b1;
                    v.alu_src2 = (fn >= 4'd8 && fn <= 4'd11);
                    exp_q.push_back(v);
                end
            end
            4'd8, 4'd11: begin
                n = (rdy >= 1 && rdy <= T_MEM) ? rdy : T_MEM;
                for (int k = 1; k <= n; k++) begin
                    v = '0; v.busy = 1'b1; v.alu_src = 1'b1;
                    if (op == 4'd11) begin
                        v.mem_write = 1'b1; v.alu_src2 = 1'b1;
                    end else begin
                        v.mem_read = 1'b1; v.mem_src = 1'b1;
                    end
                    if (k == n) begin
                        if (rdy == k) v.reg_write = (op == 4'd8);
                        else          v.mem_fault = 1'b1;
                    end
                    exp_q.push_back(v);
                end
            end
            4'd4, 4'd5, 4'd6: begin
                v = '0; v.pc_source = 2'b01; v.pc_write = bt;
                exp_q.push_back(v);
            end
            4'd12: begin
                v = '0; v.pc_source = 2'b10; v.pc_write = 1'b1;
                exp_q.push_back(v);
            end
            default: begin
                for (int k = 0; k < HALT_HOLD; k++) begin
                    v = '0; v.halt = 1'b1;
                    exp_q.push_back(v);
                end
            end
        endcase
    endtask

    // Drives one instruction for as many cycles as the model expects and records
    // the observed outputs; stops early after cycle abort_at (when >= 0).
    task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input logic bt,
                             input int rdy, input int abort_at);
        model_instr(op, fn, bt, rdy);
        obs_q.delete();
        for (int idx = 0; idx < exp_q.size(); idx++) begin
            @(negedge clk);
            opCode       = (idx <= 1) ? op : 4'($urandom);
            functionCode = (idx <= 1) ? fn : 4'($urandom);
            branchTaken  = (idx == 2) ? bt : 1'($urandom);
            if ((op == 4'd8 || op == 4'd11) && idx >= 2) memReady = (idx - 1 == rdy);
            else                                         memReady = 1'($urandom);
            #1;
            obs_q.push_back(got);
            if (idx == abort_at) return;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        opCode = 4'($urandom); functionCode = 4'($urandom);
        memReady = 1'b1; branchTaken = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (got !== outs_t'(0)) $display("FAIL reset_hold: outputs %h, expected 0", got);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (got !== outs_t'(0)) $display("FAIL idle_after_release: outputs %h, expected 0", got);
        else n_pass++;
    endtask

    task automatic test_exec();
        logic [3:0] fns [3] = '{4'd0, 4'd9, 4'd5};
        for (int t = 0; t < 3; t++) begin
            run_instr(4'd0, fns[t], 1'b0, 0, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i])
                    $display("FAIL exec fn=%0d cyc%0d: outputs %h, expected %h", fns[t], i, obs_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_muldiv();
        for (int t = 1; t <= 2; t++) begin
            run_instr(4'd0, 4'(t), 1'b0, 0, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i])
                    $display("FAIL muldiv fn=%0d cyc%0d: outputs %h, expected %h", t, i, obs_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_mem();
        logic [3:0] ops [7]  = '{4'd8, 4'd8, 4'd11, 4'd11, 4'd8, 4'd8, 4'd11};
        int         rdys [7] = '{4, 1, 1, 3, 0, T_MEM, 0};
        for (int t = 0; t < 7; t++) begin
            run_instr(ops[t], 4'($urandom), 1'b0, rdys[t], -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i])
                    $display("FAIL mem op=%0d rdy=%0d cyc%0d: outputs %h, expected %h",
                             ops[t], rdys[t], i, obs_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [3:0] ops [5] = '{4'd6, 4'd6, 4'd4, 4'd5, 4'd12};
        logic       bts [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int t = 0; t < 5; t++) begin
            run_instr(ops[t], 4'($urandom), bts[t], 0, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i])
                    $display("FAIL branch op=%0d bt=%0b cyc%0d: outputs %h, expected %h",
                             ops[t], bts[t], i, obs_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_illegal();
        run_instr(4'd3, 4'($urandom), 1'b0, 0, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL illegal cyc%0d: outputs %h, expected %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
`ifdef ILLEGAL_TRAP_EN
        apply_reset();
`endif
    endtask

    task automatic test_random();
        logic [3:0] op, fn;
        int         rdy;
        for (int t = 0; t < 40; t++) begin
            do begin
                op = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 14));
`ifdef ILLEGAL_TRAP_EN
            end while (is_illegal(op));
`else
            end while (1'b0);
`endif
            fn  = 4'($urandom);
            rdy = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            run_instr(op, fn, 1'($urandom), rdy, -1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i])
                    $display("FAIL random#%0d op=%0d fn=%0d cyc%0d: outputs %h, expected %h",
                             t, op, fn, i, obs_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_muldiv();
        run_instr(4'd0, 4'd2, 1'b0, 0, 7);
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL mid_muldiv cyc%0d: outputs %h, expected %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (got !== outs_t'(0)) $display("FAIL async_reset_muldiv: outputs %h, expected 0", got);
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_halt();
        run_instr(4'd15, 4'($urandom), 1'b0, 0, -1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL halt cyc%0d: outputs %h, expected %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_exec();
        test_muldiv();
        test_mem();
        test_branch_jump();
        test_illegal();
        test_random();
        test_reset_mid_muldiv();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
